// File: rtl/ref_loader_pkg.sv
// Shared types and constants for the reference tile loader.
package ref_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int BURST_MAX_DEF  = 16;
  localparam int BUF_DEPTH_DEF  = 256;
  localparam int BYTES_PER_WORD = 2;

  // Beats for the next burst: whatever is left, capped at the burst limit.
  function automatic logic [7:0] burst_len(input logic [15:0] remaining, input int burst_max);
    if (remaining < 16'(burst_max)) return remaining[7:0];
    else return 8'(burst_max);
  endfunction

endpackage

// File: rtl/tile_buf_bank.sv
// One tile buffer bank: simple dual-port RAM with a registered read port.
module tile_buf_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are not reset; read data appears one cycle after the address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ref_tile_loader.sv
// Reference tile prefetcher: splits a tile request into DRAM bursts and
// fills a ping-pong pair of buffer banks for the consumer.
//
//   state | meaning
//   IDLE  | waiting for a request and a free bank
//   ISSUE | burst request held on rd_req until granted
//   DATA  | accepting beats of the granted burst
//   DONE  | publish the filled bank, flip write bank
module ref_tile_loader
  import ref_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_MAX  = BURST_MAX_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  localparam int OFS_W     = $clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_len,
  output logic                  req_ack,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_beats,
  input  logic                  rd_gnt,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  tile_ready,
  output logic [15:0]           tile_len,
  input  logic [OFS_W-1:0]      buf_rd_addr,
  output logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  tile_release,
  output logic                  busy,
  output logic                  err_len
);

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [15:0]           remaining;
  logic [15:0]           fill_len;
  logic [7:0]            beat_cnt;
  logic [OFS_W-1:0]      offset;
  logic [1:0]            bank_full;
  logic [15:0]           bank_len [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  rd_sel_q;
  logic [DATA_WIDTH-1:0] bank_rdata [2];

  logic                  free_bank;
  logic                  len_bad;
  logic                  beat_wr;
  logic                  release_ok;
  logic [15:0]           remaining_nxt;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign free_bank     = ~bank_full[wr_ptr];
  assign len_bad       = (req_len == 16'd0) || (req_len > 16'(BUF_DEPTH));
  assign beat_wr       = (state == DATA) && rd_valid;
  assign release_ok    = tile_release && bank_full[rd_ptr];
  assign remaining_nxt = remaining - 16'd1;
  assign next_addr     = cur_addr + ADDR_WIDTH'(BYTES_PER_WORD) * ADDR_WIDTH'(rd_beats);

  // Loader FSM plus bank bookkeeping; release and DONE touch different banks
  // so both can land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ack     <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      rd_beats    <= '0;
      cur_addr    <= '0;
      remaining   <= '0;
      fill_len    <= '0;
      beat_cnt    <= '0;
      offset      <= '0;
      err_len     <= 1'b0;
      bank_full   <= '0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      req_ack <= 1'b0;

      if (release_ok) begin
        bank_full[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
      end

      case (state)
        IDLE: begin
          // req_ack gate keeps a still-held request from being taken twice
          if (req_valid && !req_ack && free_bank) begin
            req_ack <= 1'b1;
            if (len_bad) begin
              err_len <= 1'b1;
            end else begin
              cur_addr  <= req_addr;
              remaining <= req_len;
              fill_len  <= req_len;
              offset    <= '0;
              rd_addr   <= req_addr;
              rd_beats  <= burst_len(req_len, BURST_MAX);
              rd_req    <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (rd_gnt) begin
            rd_req   <= 1'b0;
            beat_cnt <= rd_beats;
            state    <= DATA;
          end
        end
        DATA: begin
          if (rd_valid) begin
            offset    <= offset + OFS_W'(1);
            remaining <= remaining_nxt;
            beat_cnt  <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd1) begin
              if (remaining_nxt != 16'd0) begin
                cur_addr <= next_addr;
                rd_addr  <= next_addr;
                rd_beats <= burst_len(remaining_nxt, BURST_MAX);
                rd_req   <= 1'b1;
                state    <= ISSUE;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          bank_full[wr_ptr] <= 1'b1;
          bank_len[wr_ptr]  <= fill_len;
          wr_ptr            <= ~wr_ptr;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track which bank the in-flight registered read belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sel_q <= 1'b0;
    else        rd_sel_q <= rd_ptr;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_buf_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (beat_wr && (wr_ptr == 1'(b))),
      .waddr (offset),
      .wdata (rd_data),
      .raddr (buf_rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  assign tile_ready  = bank_full[rd_ptr];
  assign tile_len    = bank_full[rd_ptr] ? bank_len[rd_ptr] : 16'd0;
  assign buf_rd_data = bank_rdata[rd_sel_q];
  assign busy        = (state != IDLE);

endmodule

// File: doc/ref_tile_loader.md
REF_TILE_LOADER -- requirements
Module: ref_tile_loader

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, byte address width; DATA_WIDTH, default 16, pixel word width; BURST_MAX, default 16, maximum beats per DRAM burst; BUF_DEPTH, default 256, words per buffer bank.
REQ-002 Ports SHALL be: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 req_valid  in  1  prefetch request present; req_addr  in  ADDR_WIDTH  tile start byte address; req_len  in  16  tile length in words; req_ack  out  1  one-cycle accept pulse.
REQ-004 rd_req  out  1  DRAM burst request; rd_addr  out  ADDR_WIDTH  burst byte address; rd_beats  out  8  burst length in words; rd_gnt  in  1  DRAM accepts burst.
REQ-005 rd_valid  in  1  DRAM data beat; rd_data  in  DATA_WIDTH  beat data.
REQ-006 tile_ready  out  1  a filled bank is readable; tile_len  out  16  word count of readable bank; buf_rd_addr  in  log2(BUF_DEPTH)  consumer word index; buf_rd_data  out  DATA_WIDTH  read data; tile_release  in  1  consumer frees readable bank.
REQ-007 busy  out  1  FSM not IDLE; err_len  out  1  sticky illegal-length flag.

Function
REQ-008 FSM states SHALL be IDLE, ISSUE, DATA, DONE.
REQ-009 IDLE: when req_valid=1 and a free bank exists, SHALL pulse req_ack for one cycle, capture addr/len, set remaining=req_len, offset=0, go ISSUE; no free bank -> stay IDLE, req_ack=0.
REQ-010 req_len=0 or req_len>BUF_DEPTH SHALL be acked, set err_len, issue no DRAM traffic, remain IDLE.
REQ-011 ISSUE: rd_req=1 with rd_beats=min(BURST_MAX, remaining), rd_addr=current address; held stable until rd_gnt; on rd_gnt go DATA, deassert rd_req next cycle.
REQ-012 Only one burst SHALL be outstanding; rd_req never asserted in DATA.
REQ-013 DATA: each rd_valid SHALL write rd_data to write bank at offset, increment offset, decrement remaining and burst beat count; rd_valid outside DATA is ignored.
REQ-014 End of burst: remaining>0 -> address += 2*rd_beats, go ISSUE; remaining=0 -> go DONE.
REQ-015 DONE: SHALL mark write bank full with its length, toggle write-bank pointer, go IDLE (one cycle).
REQ-016 Two banks (ping-pong); read bank = oldest full bank; tile_ready=1 while it is full; tile_len its length.
REQ-017 buf_rd_data SHALL be valid one cycle after buf_rd_addr (registered read).
REQ-018 tile_release with tile_ready=1 SHALL free read bank and advance read pointer next cycle; tile_release with tile_ready=0 ignored.
REQ-019 Simultaneous DONE fill and tile_release SHALL both take effect in the same cycle.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; offsets never exceed BUF_DEPTH-1.
REQ-021 err_len SHALL clear only on reset.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, both banks free, pointers 0, req_ack=0, rd_req=0, rd_addr=0, rd_beats=0, tile_ready=0, tile_len=0, err_len=0, busy=0; buffer contents undefined.
REQ-023 Reset mid-burst SHALL abandon the burst; beats arriving after release of reset while IDLE are ignored.

Structure
REQ-024 State enum, BURST_MAX/BUF_DEPTH defaults and bytes-per-word constant (2) SHALL reside in shared package ref_loader_pkg.
REQ-025 Buffer storage SHALL be one sub-module tile_buf_bank (simple dual-port, registered read), instantiated twice.

Verification
REQ-026 req_len=256, addr=0x1000, BURST_MAX=16 -> 16 bursts, rd_addr 0x1000,0x1020,...,0x11E0, tile_ready=1, tile_len=256, data readback matches.
REQ-027 req_len=20 -> bursts of 16 then 4 beats, second rd_addr=base+0x20, tile_len=20.
REQ-028 Two tiles loaded, no release -> third req_valid not acked until tile_release; after release acked within 1 cycle.
REQ-029 req_len=0 then req_len=300 -> both acked, no rd_req, err_len=1 sticky.
REQ-030 rst_n low after 5 of 16 beats -> all outputs reset values next edge; subsequent 11 rd_valid beats ignored, tile_ready=0.
REQ-031 DONE coincident with tile_release on other bank -> tile_ready stays 1, new bank becomes readable, pointers consistent.
